// File: rtl/cpm_topk_ser.sv
// Serializes a captured top-K score/tag array into a ready/valid word stream.
// Emits the first n slots (slot 0 first), then waits for the sorter to drop valid.
module cpm_topk_ser #(
    parameter int DATA_DW = 8,
    parameter int INFO_DW = 8,
    parameter int SORT_DW = 32,
    parameter int SORT_AW = $clog2(SORT_DW)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       TOPK_DAT_VLD,
    output logic                       TOPK_DAT_RDY,
    input  logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT,
    input  logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF,
    input  logic [SORT_AW:0]           OUT_NUM,
    output logic                       OUTS_DAT_VLD,
    input  logic                       OUTS_DAT_RDY,
    output logic                       OUTS_DAT_LST,
    output logic [DATA_DW-1:0]         OUTS_DAT_DAT,
    output logic [INFO_DW-1:0]         OUTS_DAT_INF,
    output logic [SORT_AW-1:0]         OUTS_DAT_IDX,
    output logic                       BUSY
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [SORT_AW:0] N_MAX = (SORT_AW+1)'(SORT_DW);

    state_t                          state_q, state_d;
    logic [SORT_AW-1:0]              ptr_q, ptr_d;
    logic [SORT_AW:0]                n_q, n_d;
    logic [SORT_DW-1:0][DATA_DW-1:0] dat_q, dat_d;
    logic [SORT_DW-1:0][INFO_DW-1:0] inf_q, inf_d;
    logic                            send;
    logic                            last;

    assign send = (state_q == SEND);
    assign last = ({1'b0, ptr_q} == n_q - 1'b1);

    assign TOPK_DAT_RDY = (state_q == IDLE) && !clear && !rst;
    assign BUSY         = (state_q != IDLE);
    assign OUTS_DAT_VLD = send;
    assign OUTS_DAT_LST = send && last;
    assign OUTS_DAT_DAT = send ? dat_q[ptr_q] : '0;
    assign OUTS_DAT_INF = send ? inf_q[ptr_q] : '0;
    assign OUTS_DAT_IDX = ptr_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        dat_d   = dat_q;
        inf_d   = inf_q;
        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (TOPK_DAT_VLD) begin
                        dat_d   = TOPK_DAT_DAT;
                        inf_d   = TOPK_DAT_INF;
                        // zero or oversize request means "emit everything"
                        n_d     = (OUT_NUM == '0 || OUT_NUM > N_MAX) ? N_MAX : OUT_NUM;
                        ptr_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (OUTS_DAT_RDY) begin
                        if (last) begin
                            ptr_d   = '0;
                            state_d = DONE;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // valid is a level held until the sorter clears; wait it out
                    if (!TOPK_DAT_VLD) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            n_q     <= N_MAX;
            dat_q   <= '0;
            inf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            n_q     <= n_d;
            dat_q   <= dat_d;
            inf_q   <= inf_d;
        end
    end
endmodule

// File: tb/tb_cpm_topk_ser.sv
// Bench for cpm_topk_ser: table of bursts against a queue-based word model,
// plus hand sequences for flush, reset-over-clear and DONE hold.
module tb_cpm_topk_ser;
    logic            clk;
    logic            rst;
    logic            clear;
    logic            topk_vld;
    logic            topk_rdy;
    logic [31:0][7:0] din_dat;
    logic [31:0][7:0] din_inf;
    logic [5:0]      out_num;
    logic            o_vld;
    logic            o_rdy;
    logic            o_lst;
    logic [7:0]      o_dat;
    logic [7:0]      o_inf;
    logic [4:0]      o_idx;
    logic            busy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] dat;
        logic [7:0] inf;
        int         idx;
        bit         lst;
    } word_t;

    typedef struct {
        int out_num;
        int exp_n;
        int mode;   // 0: fixed pattern, rdy=1; 1: random, stalls; 2: random, stalls, inputs mutate
    } vec_t;

    cpm_topk_ser dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .TOPK_DAT_VLD (topk_vld),
        .TOPK_DAT_RDY (topk_rdy),
        .TOPK_DAT_DAT (din_dat),
        .TOPK_DAT_INF (din_inf),
        .OUT_NUM      (out_num),
        .OUTS_DAT_VLD (o_vld),
        .OUTS_DAT_RDY (o_rdy),
        .OUTS_DAT_LST (o_lst),
        .OUTS_DAT_DAT (o_dat),
        .OUTS_DAT_INF (o_inf),
        .OUTS_DAT_IDX (o_idx),
        .BUSY         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp_n(input int k);
        return (k == 0 || k > 32) ? 32 : k;
    endfunction

    // Present an array, capture it, and follow the stream word by word.
    task automatic burst(input int num, input int exp_n, input int mode);
        word_t q[$];
        word_t w;
        int    cyc;
        bit    rd;
        for (int i = 0; i < 32; i++) begin
            din_dat[i] = (mode == 0) ? 8'(31 - i) : 8'($urandom);
            din_inf[i] = (mode == 0) ? 8'(i)      : 8'($urandom);
        end
        out_num  = 6'(num);
        topk_vld = 1'b1;
        o_rdy    = 1'b1;
        #1;
        chk("rdy_before_capture", topk_rdy, 1);
        chk("vld_before_capture", o_vld, 0);
        for (int i = 0; i < exp_n; i++) begin
            w.dat = din_dat[i];
            w.inf = din_inf[i];
            w.idx = i;
            w.lst = (i == exp_n - 1);
            q.push_back(w);
        end
        @(posedge clk);
        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (mode == 2) begin
                for (int i = 0; i < 32; i++) begin
                    din_dat[i] = 8'($urandom);
                    din_inf[i] = 8'($urandom);
                end
            end
            w = q[0];
            chk("word_vld", o_vld, 1);
            chk("word_dat", o_dat, w.dat);
            chk("word_inf", o_inf, w.inf);
            chk("word_idx", o_idx, w.idx);
            chk("word_lst", o_lst, w.lst);
            chk("word_busy", busy, 1);
            chk("word_topk_rdy", topk_rdy, 0);
            rd = (mode == 0) ? 1'b1 : ($urandom % 3 != 0);
            o_rdy = rd;
            @(posedge clk);
            if (rd) void'(q.pop_front());
        end
        chk("burst_words_left", q.size(), 0);
        o_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_vld", o_vld, 0);
            chk("done_lst", o_lst, 0);
            chk("done_busy", busy, 1);
            chk("done_topk_rdy", topk_rdy, 0);
        end
        topk_vld = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_topk_rdy", topk_rdy, 1);
    endtask

    vec_t vecs[$];
    int   k;

    initial begin
        rst = 1'b1; clear = 1'b0; topk_vld = 1'b0; o_rdy = 1'b0;
        out_num = '0; din_dat = '0; din_inf = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", o_vld, 0);
        chk("rst_lst", o_lst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dat", o_dat, 0);
        chk("rst_inf", o_inf, 0);
        chk("rst_idx", o_idx, 0);
        chk("rst_topk_rdy_in_rst", topk_rdy, 0);
        rst = 1'b0;
        #1;
        chk("rst_topk_rdy_after", topk_rdy, 1);
        @(negedge clk);

        vecs.push_back('{0, 32, 0});
        vecs.push_back('{4, 4, 1});
        vecs.push_back('{40, 32, 1});
        vecs.push_back('{1, 1, 1});
        vecs.push_back('{63, 32, 2});
        vecs.push_back('{31, 31, 2});
        vecs.push_back('{32, 32, 1});
        vecs.push_back('{2, 2, 2});
        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(0, 63));
            vecs.push_back('{k, clamp_n(k), 2});
        end
        foreach (vecs[i]) burst(vecs[i].out_num, vecs[i].exp_n, vecs[i].mode);

        // Flush at ptr=5, then a fresh capture must restart at slot 0.
        for (int i = 0; i < 32; i++) begin
            din_dat[i] = 8'($urandom);
            din_inf[i] = 8'($urandom);
        end
        out_num = '0; topk_vld = 1'b1; o_rdy = 1'b1;
        @(posedge clk);
        repeat (6) @(negedge clk);
        chk("flush_idx_at_cut", o_idx, 5);
        chk("flush_lst_at_cut", o_lst, 0);
        clear = 1'b1; topk_vld = 1'b0;
        @(negedge clk);
        chk("flush_vld", o_vld, 0);
        chk("flush_lst", o_lst, 0);
        chk("flush_busy", busy, 0);
        chk("flush_idx", o_idx, 0);
        chk("flush_topk_rdy_clear_hi", topk_rdy, 0);
        clear = 1'b0;
        #1;
        chk("flush_topk_rdy", topk_rdy, 1);
        burst(3, 3, 1);

        // Reset mid-burst with clear also high: reset wins, block idles.
        for (int i = 0; i < 32; i++) begin
            din_dat[i] = 8'($urandom);
            din_inf[i] = 8'($urandom);
        end
        out_num = 6'd10; topk_vld = 1'b1; o_rdy = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("rstmid_idx_at_cut", o_idx, 2);
        rst = 1'b1; clear = 1'b1; topk_vld = 1'b0;
        @(negedge clk);
        chk("rstmid_vld", o_vld, 0);
        chk("rstmid_lst", o_lst, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_dat", o_dat, 0);
        chk("rstmid_idx", o_idx, 0);
        chk("rstmid_topk_rdy", topk_rdy, 0);
        rst = 1'b0; clear = 1'b0;
        #1;
        chk("rstmid_topk_rdy_after", topk_rdy, 1);
        burst(0, 32, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cpm_topk_ser.md
CPM_TOPK_SER -- requirements
Module: cpm_topk_ser

Interface
REQ-001 SHALL have parameter DATA_DW, default 8, the width of each score word.
REQ-002 SHALL have parameter INFO_DW, default 8, the width of each tag word.
REQ-003 SHALL have parameter SORT_DW, default 32, the number of top-K slots.
REQ-004 SHALL have parameter SORT_AW, default $clog2(SORT_DW), the slot index width.
REQ-005 SHALL have one clock and a synchronous, active-high reset; all state changes on rising clk.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clear  input  1  synchronous flush; returns block to IDLE.
REQ-009 TOPK_DAT_VLD  input  1  top-K array valid (level; held high until sorter clear).
REQ-010 TOPK_DAT_RDY  output  1  block can capture the array.
REQ-011 TOPK_DAT_DAT  input  SORT_DW x DATA_DW  scores, slot 0 = largest.
REQ-012 TOPK_DAT_INF  input  SORT_DW x INFO_DW  tags per slot.
REQ-013 OUT_NUM  input  SORT_AW+1  number of slots to emit.
REQ-014 OUTS_DAT_VLD  output  1  serial word valid.
REQ-015 OUTS_DAT_RDY  input  1  downstream ready.
REQ-016 OUTS_DAT_LST  output  1  last word of the burst.
REQ-017 OUTS_DAT_DAT  output  DATA_DW  serial score.
REQ-018 OUTS_DAT_INF  output  INFO_DW  serial tag.
REQ-019 OUTS_DAT_IDX  output  SORT_AW  slot index of the current word.
REQ-020 BUSY  output  1  high in SEND or DONE.

Function
REQ-021 FSM states SHALL be IDLE, SEND and DONE.
REQ-022 TOPK_DAT_RDY SHALL be 1 only in IDLE, with clear and rst low.
REQ-023 Capture:
- Condition: IDLE and TOPK_DAT_VLD=1.
- Action: copy all SORT_DW DAT/INF slots into shadow registers.
- Latch n = OUT_NUM, with OUT_NUM=0 or OUT_NUM>SORT_DW mapping to SORT_DW.
- Set ptr=0 and go to SEND.
REQ-024 Latency: OUTS_DAT_VLD SHALL rise the cycle after capture, showing slot 0.
REQ-025 In SEND, OUTS_DAT_VLD SHALL be 1; DAT/INF SHALL be shadow[ptr] and IDX SHALL equal ptr.
REQ-026 On OUTS_DAT_VLD && OUTS_DAT_RDY, ptr SHALL increment by 1.
REQ-027 With OUTS_DAT_RDY low, the outputs SHALL hold stable.
REQ-028 OUTS_DAT_LST SHALL be 1 exactly when ptr == n-1 in SEND.
REQ-029 After the LST handshake, the FSM SHALL go to DONE and OUTS_DAT_VLD SHALL drop the next cycle.
REQ-030 DONE SHALL go to IDLE once TOPK_DAT_VLD is sampled 0, so one sorter result is never emitted twice.
REQ-031 Shadow registers SHALL be isolated from input changes after capture.
REQ-032 clear SHALL take priority over every transition:
- Next cycle: state IDLE, ptr 0, VLD/LST 0.
- Shadow contents are don't-care.
REQ-033 An in-flight burst cut by clear SHALL NOT issue LST.
REQ-034 ptr SHALL never exceed SORT_DW-1; no wrap-around.

Reset
REQ-035 On rst, the FSM SHALL be IDLE with ptr=0 and n=SORT_DW.
REQ-036 On rst, OUTS_DAT_VLD, OUTS_DAT_LST and BUSY SHALL be 0, and OUTS_DAT_DAT/INF/IDX SHALL be 0.
REQ-037 On rst, shadow registers SHALL be 0, and TOPK_DAT_RDY SHALL be 1 from the first cycle after rst deasserts.
REQ-038 rst asserted mid-burst SHALL behave identically to clear, and rst SHALL dominate clear.

Verification
REQ-039 Full burst:
- Stimulus: SORT_DW=32, slot i = 31-i, INF=i, OUT_NUM=0, RDY=1.
- Response: 32 words, DAT 31..0, IDX 0..31, LST only on word 32.
- Timing: first VLD 1 cycle after capture.
REQ-040 Partial burst:
- Stimulus: OUT_NUM=4.
- Response: 4 words, IDX 0..3, LST on IDX 3.
- Then: DONE holds until TOPK_DAT_VLD goes low, with no second burst.
REQ-041 Backpressure:
- Stimulus: OUTS_DAT_RDY toggles 1,0,0,1 pseudo-randomly.
- Response: no word lost or duplicated, and outputs stay stable on every stall cycle.
REQ-042 Input isolation:
- Stimulus: change TOPK_DAT_DAT while in SEND.
- Response: emitted words still match the captured values.
REQ-043 Mid-burst flush:
- Stimulus: assert clear at ptr=5.
- Response: VLD 0 the next cycle and no LST.
- Then: RDY 1; a new capture works with ptr restarting at 0.
REQ-044 Clamp:
- Stimulus: OUT_NUM=40 with SORT_DW=32.
- Response: 32 words emitted.
- Also: OUT_NUM=1 gives a single word with LST=1.
